// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of WIDTH JK flip-flops.
// Takes one command at a time over valid/ready and drives the bank with
// registered J/K values. It runs single-cycle SET/CLR/TOG/LOAD operations
// and multi-step up/down counts.
//
// Handshake: a command transfers on a rising clock edge when iCmdValid and
// oCmdReady are both high. oCmdReady is high only in IDLE and only while
// reset is released. While the controller is busy, the requester keeps
// iCmdValid and the command fields stable. A command presented while busy
// is not consumed.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int LENW  = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [2:0]       iCmd,
  input  logic [WIDTH-1:0] iMask,
  input  logic [WIDTH-1:0] iLoad,
  input  logic [LENW-1:0]  iCntLen,
  input  logic             iAbort,
  input  logic [WIDTH-1:0] iQ,
  output logic [WIDTH-1:0] oJ,
  output logic [WIDTH-1:0] oK,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr,
  output logic [1:0]       oState
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_CLR   = 3'd2;
  localparam logic [2:0] OP_TOG   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_CNTUP = 3'd5;
  localparam logic [2:0] OP_CNTDN = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CSTEP = 2'd2,
    CHOLD = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       cmd_q;
  logic [LENW-1:0]  rem;
  logic [WIDTH-1:0] t_vec;
  logic             run;
  logic             accept;
  logic             is_count;

  assign oCmdReady = (state == IDLE) && iRst_n;
  assign accept    = iCmdValid && oCmdReady;
  assign oBusy     = (state != IDLE);
  assign oState    = state;
  assign is_count  = (iCmd == OP_CNTUP) || (iCmd == OP_CNTDN);

  // Toggle vector for one counter step. Bit i toggles when every lower bit
  // is 1 (counting up) or every lower bit is 0 (counting down).
  always_comb begin
    t_vec = '0;
    run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_vec[i] = run;
      run      = run & ((cmd_q == OP_CNTDN) ? ~iQ[i] : iQ[i]);
    end
  end

  // Sequencer FSM. J/K, done and err are all registered. oJ/oK are cleared
  // after every step, so each count step toggles the bank exactly once.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      oJ    <= '0;
      oK    <= '0;
      oDone <= 1'b0;
      oErr  <= 1'b0;
      cmd_q <= '0;
      rem   <= '0;
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;
      case (state)
        IDLE: begin
          oJ <= '0;
          oK <= '0;
          if (accept) begin
            cmd_q <= iCmd;
            rem   <= iCntLen;
            if (is_count && (iCntLen != '0)) begin
              state <= CSTEP;
            end else begin
              state <= APPLY;
              case (iCmd)
                OP_SET:  begin oJ <= iMask;          oK <= '0;             end
                OP_CLR:  begin oJ <= '0;             oK <= iMask;          end
                OP_TOG:  begin oJ <= iMask;          oK <= iMask;          end
                OP_LOAD: begin oJ <= iLoad & iMask;  oK <= ~iLoad & iMask; end
                default: begin oJ <= '0;             oK <= '0;             end
              endcase
            end
          end
        end
        APPLY: begin
          oJ    <= '0;
          oK    <= '0;
          state <= IDLE;
          oDone <= 1'b1;
          oErr  <= (cmd_q == OP_RSVD);
        end
        CSTEP: begin
          oJ    <= t_vec;
          oK    <= t_vec;
          rem   <= rem - LENW'(1);
          state <= CHOLD;
        end
        CHOLD: begin
          oJ <= '0;
          oK <= '0;
          if ((rem == '0) || iAbort) begin
            state <= IDLE;
            oDone <= 1'b1;
          end else begin
            state <= CSTEP;
          end
        end
        default: begin
          state <= IDLE;
          oJ    <= '0;
          oK    <= '0;
        end
      endcase
    end
  end

  // OP_NOP is handled by the default drive branch; keep the name for readers.
  localparam logic [2:0] OP_UNUSED_NOP = OP_NOP;

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
Command sequencer for a bank of WIDTH JK flip-flops. The bank has no reset and no enable; this block drives every J/K pair and reads back the Q vector. It accepts one command at a time over a valid/ready handshake and executes SET, CLEAR, TOGGLE, LOAD and multi-step up/down COUNT sequences. The bank is driven with registered J/K values only.

Parameters:
WIDTH, 4, number of JK flip-flops in the controlled bank (1..16)
LENW, 8, width of the count-length field

Ports:
iClk  in  1  clock, rising edge; shared with the JK bank
iRst_n  in  1  asynchronous active-low reset
iCmdValid  in  1  command present
oCmdReady  out  1  controller can accept a command
iCmd  in  3  opcode: 0 NOP, 1 SET, 2 CLR, 3 TOG, 4 LOAD, 5 CNTUP, 6 CNTDN, 7 reserved
iMask  in  WIDTH  bit select for SET/CLR/TOG/LOAD
iLoad  in  WIDTH  LOAD data
iCntLen  in  LENW  number of count steps
iAbort  in  1  stop a count after the current step
iQ  in  WIDTH  Q feedback from the bank
oJ  out  WIDTH  J drive to the bank (registered)
oK  out  WIDTH  K drive to the bank (registered)
oBusy  out  1  state != IDLE
oDone  out  1  one-cycle pulse when a command completes
oErr  out  1  one-cycle pulse, coincident with oDone, for a reserved opcode

Behaviour:
- Reset (async, iRst_n=0): state=IDLE, oJ=oK=0, oDone=oErr=0, step counter=0, latched cmd/mask/load=0. Release takes effect at the next posedge. Bank Q content is not reset; use CLR with mask all-ones.
- States: IDLE, APPLY, CSTEP, CHOLD.
- oCmdReady=1 only in IDLE with iRst_n=1. Accept = iCmdValid & oCmdReady at a posedge (E0). Latch iCmd, iMask, iLoad and iCntLen at E0. iCmdValid while busy is ignored; the requester holds it.
- IDLE, accept of opcode 0..4 or 7, at E0: go to APPLY and register the drive:
  - SET: J=mask, K=0
  - CLR: J=0, K=mask
  - TOG: J=K=mask
  - LOAD: J=load&mask, K=~load&mask
  - NOP/7: J=K=0
- APPLY, at E1: the bank samples the drive. Registered updates: oJ=oK=0, state=IDLE, oDone=1, and oErr=1 if opcode 7. Single-op latency: oDone high during the cycle after E1; iQ reflects the result in that same cycle.
- IDLE, accept of CNTUP/CNTDN:
  - iCntLen=0: behave as NOP.
  - Otherwise: go to CSTEP with rem=iCntLen and oJ=oK=0.
- CSTEP, at the edge: register oJ=oK=T(iQ) and rem=rem-1, then go to CHOLD.
  - Up: T[0]=1; T[i]=&iQ[i-1:0].
  - Down: T[0]=1; T[i]=~|iQ[i-1:0].
- CHOLD, at the edge: the bank applies T; register oJ=oK=0. If rem==0 or iAbort=1, go to IDLE with oDone=1. Otherwise go to CSTEP. Each step is 2 cycles. A length-L count completes at edge E0+2L.
- Wrap-around: up from all-ones goes to 0; down from 0 goes to all-ones. This follows naturally from T; no special case.
- iAbort is sampled only in CHOLD. The step in flight always completes, and oDone still pulses. iAbort in other states has no effect.
- oJ/oK are never nonzero for two consecutive cycles in COUNT, so each step toggles exactly once.
- oDone and oErr are high for exactly one cycle. A new command may be accepted in the same cycle oDone is high.
- Reset mid-operation: immediate return to IDLE with outputs zeroed. A bank toggle already sampled stands; none follows.

Test Plan:
1. Reset, then CLR mask=F → oJ=0, oK=F for 1 cycle; iQ=0; oDone 1 cycle after E1; oCmdReady back high.
2. From Q=0: SET mask=5, TOG mask=3, LOAD load=9 mask=C → Q=5, then 6, then A. Each op: oDone one cycle, oJ/oK return to 0.
3. Q=D, CNTUP len=3 → Q sequence E, F, 0 (wrap). oBusy high for 6 cycles; oDone at E0+6. CNTDN len=2 from 0 → F, E.
4. CNTUP len=200 from 0, iAbort pulsed during the 3rd CHOLD → stops at Q=3 with a single oDone; CNTUP len=0 → NOP timing, Q unchanged.
5. Opcode 7 → oErr and oDone together, Q unchanged. iCmdValid held during a count → accepted only in the cycle after oDone.
6. iRst_n low mid-count (after 2 steps from 0) → oJ=oK=0 asynchronously, oBusy=0, Q stays 2, no oDone.
